mouse_axis_adapter: RTL and testbench
=====================================

Name: mouse_axis_adapter

Overview:
Converts PS/2 mouse packets from hps_io (25-bit ps2_mouse bus, toggle strobe) into the first-player analog axes and paddle buttons consumed by atari800top (JOY1X/JOY1Y, JOY1[8:7]). It sits directly upstream of atari800top. It arbitrates between mouse input and the analog joystick.
- Mouse deltas: scaled, per-packet clamped, and integrated into saturating signed 8-bit positions.
- Analog joystick: any non-zero stick value, or CPU halt, returns control to the joystick.

Parameters:
MAX_STEP, 10, per-packet delta clamp magnitude (1..127)
SENS_SHIFT, 1, arithmetic right shift applied to raw 9-bit delta (0..4)
INVERT_Y, 0, 1 = negate Y delta before clamping
IDLE_CYCLES, 0, cycles without a packet before returning to joystick mode; 0 = never

Ports:
CLK  in  1  system clock (clk_sys)
RESET_N  in  1  synchronous active-low reset
PS2_MOUSE  in  25  [24] toggle strobe, [5] Y sign, [4] X sign, [1:0] buttons, [15:8] dX, [23:16] dY
JOYA  in  16  analog joystick, [7:0] X, [15:8] Y, signed
JOY_BTN  in  2  joystick paddle buttons (joy_0[8:7])
HALT  in  1  CPU halt (menu/OSD active)
AXIS_X  out  8  signed X to JOY1X
AXIS_Y  out  8  signed Y to JOY1Y
BTN  out  2  paddle buttons to JOY1[8:7]
MOUSE_ACT  out  1  1 = mouse mode
PKT_STB  out  1  one-cycle pulse when the mouse accumulator updates

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous, active-low on RESET_N. All state updates on the rising edge of CLK.
- Reset values:
  - AXIS_X = AXIS_Y = 0, BTN = 0, MOUSE_ACT = 0, PKT_STB = 0.
  - Accumulators = 0, mode = JOY, stage-1 valid = 0.
  - stb_d loads PS2_MOUSE[24], so no spurious packet is seen after reset.
- Packet accept: packet seen at edge k when PS2_MOUSE[24] != stb_d. At that edge: stb_d is updated, raw fields are captured into stage 1, and s1_valid = 1.
- Stage 1 to accumulate, at edge k+1:
  - raw = {sign, byte} as a 9-bit signed value.
  - d = raw >>> SENS_SHIFT; Y is negated when INVERT_Y = 1.
  - d is clamped to [-MAX_STEP, +MAX_STEP].
  - acc = sat(acc + d) to [-128, 127], computed with a 10-bit intermediate.
  - BTN latches the captured buttons. PKT_STB = 1 for one cycle. mode = MOUSE.
- Packet latency: 2 edges from strobe toggle to AXIS update.
- States:
  - JOY -> MOUSE on an accumulated packet while there is no override.
  - MOUSE -> JOY on override, or on idle timeout.
  - Idle timeout: counter reaches IDLE_CYCLES (IDLE_CYCLES > 0). The counter clears on each accept and saturates.
- Override: (JOYA != 0) || HALT.
  - mode = JOY, both accumulators = 0, s1_valid = 0, idle counter = 0.
  - Override beats a packet in the same cycle; the packet is dropped but stb_d still updates.
- Idle timeout clears both accumulators.
- Outputs are registered:
  - JOY mode: AXIS_X = JOYA[7:0], AXIS_Y = JOYA[15:8], BTN = JOY_BTN, with 1-edge latency.
  - MOUSE mode: AXIS = acc, BTN = last mouse buttons.
  - MOUSE_ACT = (mode == MOUSE).
- Back-to-back packets on consecutive edges: each packet is accumulated in order. No packet is lost, because stage 1 drains every cycle.
- Reset mid-packet discards stage 1.

Decomposition:
- Package atari_input_pkg:
  - typedef enum mode_e {JOY, MOUSE};
  - localparams AXIS_MIN = -128, AXIS_MAX = 127;
  - ps2_mouse field bit positions (STB = 24, XS = 4, YS = 5, DX_LSB = 8, DY_LSB = 16).
- Sub-module axis_accum, instantiated twice (X, Y): shift, optional negate, clamp, and saturating add with a clear input.
- Top level holds the strobe detect, stage 1, mode FSM, idle counter and output mux.

Test Plan:
1. Reset with PS2_MOUSE[24] = 1, then release and hold it -> PKT_STB never pulses, AXIS 0/0, MOUSE_ACT = 0.
2. Toggle the strobe with dX = 0x28, X sign 0, defaults -> 20 is clamped to 10; AXIS_X = 10 two edges later, MOUSE_ACT = 1, PKT_STB pulse. 13 identical packets -> AXIS_X = 127 (12*10 = 120, then saturates).
3. Packets with X sign 1, dX = 0xFD (-3 >>> 1 = -2) from AXIS_X = 0 -> -2, -4, ...; 70 packets -> AXIS_X = -128, no wrap.
4. In MOUSE mode with acc X = 50, set JOYA = 0x3050 -> next edge MOUSE_ACT = 0, AXIS_X = 0x50, AXIS_Y = 0x30. Then JOYA = 0 plus a packet with dX = 4 -> AXIS_X = 2.
5. Strobe toggle in the same cycle as HALT = 1 -> no PKT_STB, MOUSE_ACT = 0, AXIS = JOYA. The next toggle after HALT = 0 is accepted normally.
6. IDLE_CYCLES = 100: one packet with dX = 8, then 100 idle cycles -> MOUSE_ACT falls to 0, AXIS_X = JOYA[7:0]. The next packet restarts from acc = 0.

Source files
------------

// File: rtl/atari_input_pkg.sv
// Shared types, limits and PS/2 mouse bus layout for the Atari input path.
package atari_input_pkg;

    typedef enum logic {
        JOY   = 1'b0,
        MOUSE = 1'b1
    } mode_e;

    localparam int AXIS_MIN = -128;
    localparam int AXIS_MAX = 127;

    localparam int STB     = 24;
    localparam int XS      = 4;
    localparam int YS      = 5;
    localparam int DX_LSB  = 8;
    localparam int DY_LSB  = 16;
    localparam int BTN_LSB = 0;

    function automatic logic [7:0] sat_axis(input logic signed [9:0] v);
        if (v > $signed(10'(AXIS_MAX))) return 8'(AXIS_MAX);
        if (v < $signed(10'(AXIS_MIN))) return 8'(AXIS_MIN);
        return v[7:0];
    endfunction

endpackage

// File: rtl/axis_accum.sv
// One mouse axis: scale, optional negate, per-packet clamp and saturating integrate.
module axis_accum
    import atari_input_pkg::*;
#(
    parameter int MAX_STEP   = 10,
    parameter int SENS_SHIFT = 1,
    parameter bit NEGATE     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       sign,
    input  logic [7:0] mag,
    output logic [7:0] acc_nxt
);

    localparam logic signed [9:0] STEP_HI = 10'(MAX_STEP);
    localparam logic signed [9:0] STEP_LO = -STEP_HI;

    logic [7:0]        acc;
    logic signed [9:0] d_shift;
    logic signed [9:0] d_dir;
    logic signed [9:0] d_clamp;
    logic signed [9:0] sum;

    always_comb begin
        // Widen before shifting/negating so -256 survives negation.
        d_shift = $signed({sign, sign, mag}) >>> SENS_SHIFT;
        d_dir   = NEGATE ? -d_shift : d_shift;
        d_clamp = d_dir;
        if (d_dir > STEP_HI) d_clamp = STEP_HI;
        else if (d_dir < STEP_LO) d_clamp = STEP_LO;
        sum     = $signed({{2{acc[7]}}, acc}) + d_clamp;
        acc_nxt = acc;
        if (clear) acc_nxt = '0;
        else if (en) acc_nxt = sat_axis(sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) acc <= '0;
        else        acc <= acc_nxt;
    end

endmodule

// File: rtl/mouse_axis_adapter.sv
// Arbitrates PS/2 mouse packets against the analog joystick for player-one axes.
module mouse_axis_adapter
    import atari_input_pkg::*;
#(
    parameter int MAX_STEP    = 10,
    parameter int SENS_SHIFT  = 1,
    parameter bit INVERT_Y    = 1'b0,
    parameter int IDLE_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [24:0] PS2_MOUSE,
    input  logic [15:0] JOYA,
    input  logic [1:0]  JOY_BTN,
    input  logic        HALT,
    output logic [7:0]  AXIS_X,
    output logic [7:0]  AXIS_Y,
    output logic [1:0]  BTN,
    output logic        MOUSE_ACT,
    output logic        PKT_STB
);

    localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    logic          stb_d;
    logic          s1_valid;
    logic          s1_xs, s1_ys;
    logic [7:0]    s1_dx, s1_dy;
    logic [1:0]    s1_btn;
    mode_e         mode, mode_nxt;
    logic [IW-1:0] idle_cnt;
    logic          override, accept, acc_en, timeout;
    logic [7:0]    nxt_x, nxt_y;
    logic          unused_bits;

    assign unused_bits = ^{PS2_MOUSE[7:6], PS2_MOUSE[3:2]};
    assign override    = (JOYA != 16'd0) || HALT;
    assign accept      = (PS2_MOUSE[STB] != stb_d) && !override;
    assign acc_en      = s1_valid && !override;
    assign timeout     = (IDLE_CYCLES > 0) && (mode == MOUSE) && (idle_cnt == IDLE_MAX);
    assign MOUSE_ACT   = (mode == MOUSE);

    // The strobe is tracked even under override so a dropped packet is not replayed.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stb_d    <= PS2_MOUSE[STB];
            s1_valid <= 1'b0;
            s1_xs    <= 1'b0;
            s1_ys    <= 1'b0;
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_btn   <= '0;
        end else begin
            stb_d    <= PS2_MOUSE[STB];
            s1_valid <= accept;
            if (accept) begin
                s1_xs  <= PS2_MOUSE[XS];
                s1_ys  <= PS2_MOUSE[YS];
                s1_dx  <= PS2_MOUSE[DX_LSB +: 8];
                s1_dy  <= PS2_MOUSE[DY_LSB +: 8];
                s1_btn <= PS2_MOUSE[BTN_LSB +: 2];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N || override || accept) idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)      idle_cnt <= idle_cnt + IW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) mode <= JOY;
        else          mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode;
        if (override)     mode_nxt = JOY;
        else if (acc_en)  mode_nxt = MOUSE;
        else if (timeout) mode_nxt = JOY;
    end

    axis_accum #(.MAX_STEP(MAX_STEP), .SENS_SHIFT(SENS_SHIFT), .NEGATE(1'b0)) u_acc_x (
        .clk(CLK), .rst_n(RESET_N), .clear(override || timeout), .en(acc_en),
        .sign(s1_xs), .mag(s1_dx), .acc_nxt(nxt_x)
    );

    axis_accum #(.MAX_STEP(MAX_STEP), .SENS_SHIFT(SENS_SHIFT), .NEGATE(INVERT_Y)) u_acc_y (
        .clk(CLK), .rst_n(RESET_N), .clear(override || timeout), .en(acc_en),
        .sign(s1_ys), .mag(s1_dy), .acc_nxt(nxt_y)
    );

    // Outputs follow the next mode so a mode change is visible on the same edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            AXIS_X  <= '0;
            AXIS_Y  <= '0;
            BTN     <= '0;
            PKT_STB <= 1'b0;
        end else begin
            AXIS_X  <= (mode_nxt == MOUSE) ? nxt_x : JOYA[7:0];
            AXIS_Y  <= (mode_nxt == MOUSE) ? nxt_y : JOYA[15:8];
            BTN     <= acc_en ? s1_btn : ((mode_nxt == MOUSE) ? BTN : JOY_BTN);
            PKT_STB <= acc_en;
        end
    end

endmodule

// File: tb/tb_mouse_axis_adapter.sv
// Bench for mouse_axis_adapter: two parameterisations against a behavioural model.
module tb_mouse_axis_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] ps2;
    logic [15:0] joya;
    logic [1:0]  joy_btn;
    logic        halt;

    logic [7:0] ax0, ay0, ax1, ay1;
    logic [1:0] btn0, btn1;
    logic       act0, act1, stb0, stb1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mouse_axis_adapter #(.MAX_STEP(10), .SENS_SHIFT(1), .INVERT_Y(1'b0), .IDLE_CYCLES(100)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .PS2_MOUSE(ps2), .JOYA(joya), .JOY_BTN(joy_btn), .HALT(halt),
        .AXIS_X(ax0), .AXIS_Y(ay0), .BTN(btn0), .MOUSE_ACT(act0), .PKT_STB(stb0)
    );

    mouse_axis_adapter #(.MAX_STEP(127), .SENS_SHIFT(0), .INVERT_Y(1'b1), .IDLE_CYCLES(0)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .PS2_MOUSE(ps2), .JOYA(joya), .JOY_BTN(joy_btn), .HALT(halt),
        .AXIS_X(ax1), .AXIS_Y(ay1), .BTN(btn1), .MOUSE_ACT(act1), .PKT_STB(stb1)
    );

    // ---------------- behavioural model ----------------
    function automatic int p_max(int i);   return (i == 0) ? 10  : 127; endfunction
    function automatic int p_shift(int i); return (i == 0) ? 1   : 0;   endfunction
    function automatic bit p_inv(int i);   return (i == 0) ? 1'b0 : 1'b1; endfunction
    function automatic int p_idle(int i);  return (i == 0) ? 100 : 0;   endfunction

    typedef struct {
        bit       xs, ys;
        int       dx, dy;
        bit [1:0] btn;
    } pkt_t;

    bit   m_stb_d;
    bit   started = 1'b0;
    bit   m_mouse [2];
    int   m_acc_x [2];
    int   m_acc_y [2];
    int   m_idle  [2];
    bit   m_pend_v[2];
    pkt_t m_pend  [2];
    logic [7:0] e_ax [2];
    logic [7:0] e_ay [2];
    logic [1:0] e_btn[2];
    bit   e_act[2];
    bit   e_stb[2];

    function automatic int delta(bit s, int mag, int i, bit is_y);
        int raw, d;
        raw = s ? mag - 256 : mag;
        d = raw >>> p_shift(i);
        if (is_y && p_inv(i)) d = -d;
        if (d > p_max(i)) d = p_max(i);
        if (d < -p_max(i)) d = -p_max(i);
        return d;
    endfunction

    function automatic int sat(int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_step();
        bit ovr, newp, tmo;
        ovr = (joya != 16'd0) || halt;
        newp = (ps2[24] != m_stb_d);
        m_stb_d = ps2[24];
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_mouse[i] = 0; m_acc_x[i] = 0; m_acc_y[i] = 0; m_idle[i] = 0; m_pend_v[i] = 0;
                e_ax[i] = 0; e_ay[i] = 0; e_btn[i] = 0; e_act[i] = 0; e_stb[i] = 0;
                continue;
            end
            e_stb[i] = 0;
            tmo = (p_idle(i) > 0) && m_mouse[i] && (m_idle[i] >= p_idle(i));
            if (ovr) begin
                m_mouse[i] = 0; m_acc_x[i] = 0; m_acc_y[i] = 0; m_pend_v[i] = 0; m_idle[i] = 0;
            end else begin
                if (m_pend_v[i]) begin
                    m_acc_x[i] = sat(m_acc_x[i] + delta(m_pend[i].xs, m_pend[i].dx, i, 1'b0));
                    m_acc_y[i] = sat(m_acc_y[i] + delta(m_pend[i].ys, m_pend[i].dy, i, 1'b1));
                    e_btn[i] = m_pend[i].btn;
                    e_stb[i] = 1;
                    m_mouse[i] = 1;
                    m_pend_v[i] = 0;
                end else if (tmo) begin
                    m_mouse[i] = 0; m_acc_x[i] = 0; m_acc_y[i] = 0;
                end
                if (newp) begin
                    m_pend[i].xs = ps2[4];
                    m_pend[i].ys = ps2[5];
                    m_pend[i].dx = int'(ps2[15:8]);
                    m_pend[i].dy = int'(ps2[23:16]);
                    m_pend[i].btn = ps2[1:0];
                    m_pend_v[i] = 1;
                    m_idle[i] = 0;
                end else if (m_idle[i] < p_idle(i)) begin
                    m_idle[i]++;
                end
            end
            if (m_mouse[i]) begin
                e_ax[i] = 8'(m_acc_x[i]);
                e_ay[i] = 8'(m_acc_y[i]);
            end else begin
                e_ax[i] = joya[7:0];
                e_ay[i] = joya[15:8];
                e_btn[i] = joy_btn;
            end
            e_act[i] = m_mouse[i];
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("ax0", ax0, e_ax[0]);   check("ay0", ay0, e_ay[0]);
            check("btn0", btn0, e_btn[0]); check("act0", act0, e_act[0]);
            check("stb0", stb0, e_stb[0]);
            check("ax1", ax1, e_ax[1]);   check("ay1", ay1, e_ay[1]);
            check("btn1", btn1, e_btn[1]); check("act1", act1, e_act[1]);
            check("stb1", stb1, e_stb[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit xs, input bit [7:0] dx, input bit ys, input bit [7:0] dy,
                        input bit [1:0] b);
        ps2[24]    = ~ps2[24];
        ps2[4]     = xs;
        ps2[5]     = ys;
        ps2[15:8]  = dx;
        ps2[23:16] = dy;
        ps2[1:0]   = b;
        @(negedge clk);
    endtask

    task automatic joy_clear();
        joya = 16'h0001;
        tick(1);
        joya = 16'h0000;
        tick(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; ps2 = 25'h1000000; joya = '0; joy_btn = '0; halt = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("t1_ax", ax0, 0); check("t1_act", act0, 0); check("t1_stb", stb0, 0);

        send(1'b0, 8'h28, 1'b0, 8'h00, 2'b01);
        tick(1);
        check("t2_ax_first", ax0, 10); check("t2_act", act0, 1);
        check("t2_stb", stb0, 1); check("t2_btn", btn0, 1); check("t2_ax1_first", ax1, 40);
        repeat (12) send(1'b0, 8'h28, 1'b0, 8'h00, 2'b01);
        tick(1);
        check("t2_ax_sat", ax0, 127);

        joy_clear();
        send(1'b1, 8'hFD, 1'b0, 8'h00, 2'b00);
        tick(1);
        check("t3_ax_first", ax0, 8'hFE);
        repeat (69) send(1'b1, 8'hFD, 1'b0, 8'h00, 2'b00);
        tick(1);
        check("t3_ax_min", ax0, 8'h80); check("t3_ax1_min", ax1, 8'h80);

        joy_clear();
        repeat (5) send(1'b0, 8'h28, 1'b0, 8'h00, 2'b00);
        tick(1);
        check("t4_ax50", ax0, 50);
        joya = 16'h3050;
        tick(1);
        check("t4_act", act0, 0); check("t4_ax", ax0, 8'h50); check("t4_ay", ay0, 8'h30);
        joya = 16'h0000;
        send(1'b0, 8'h04, 1'b0, 8'h05, 2'b10);
        tick(1);
        check("t4_ax2", ax0, 2); check("t4_ay0", ay0, 2); check("t4_ay1_inv", ay1, 8'hFB);

        halt = 1'b1;
        send(1'b0, 8'h10, 1'b0, 8'h00, 2'b00);
        check("t5_act", act0, 0); check("t5_ax", ax0, 0);
        halt = 1'b0;
        tick(3);
        check("t5_stb", stb0, 0);
        send(1'b0, 8'h04, 1'b0, 8'h00, 2'b00);
        tick(1);
        check("t5_ax", ax0, 2); check("t5_stb_after", stb0, 1);

        joy_clear();
        send(1'b0, 8'h08, 1'b0, 8'h00, 2'b00);
        tick(1);
        check("t6_ax", ax0, 4);
        tick(50);
        check("t6_act_mid", act0, 1);
        tick(60);
        check("t6_act_idle", act0, 0); check("t6_ax_joy", ax0, 0); check("t6_act1_noidle", act1, 1);
        send(1'b0, 8'h08, 1'b0, 8'h00, 2'b00);
        tick(1);
        check("t6_ax_restart", ax0, 4); check("t6_ax1_keep", ax1, 16);

        for (int n = 0; n < 2500; n++) begin
            joya    = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0000;
            halt    = ($urandom_range(0, 31) == 0);
            joy_btn = 2'($urandom_range(0, 3));
            rst_n   = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 99) == 0) begin
                joya = '0; halt = 1'b0; rst_n = 1'b1;
                tick($urandom_range(90, 130));
            end else if ($urandom_range(0, 99) < 40) begin
                send(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 2'($urandom));
            end else begin
                tick(1);
            end
        end

        rst_n = 1'b1; joya = '0; halt = 1'b0;
        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
